pipearch_storereg: RTL and testbench

Stores one 32-bit register value into a single word of a 512-bit line in an on-chip FIFO/BRAM region. It is the store-side counterpart of the register-load instruction and is launched by the same instruction engine through the `op_start`/`op_done` handshake. The region is written one line at a time, so the block performs a read-modify-write: it reads the line, replaces one 32-bit word and writes the line back. Completion is signalled only after the write has been issued, so a following load observes the new value.

---
 rtl/pipearch_storereg.sv | 133 +++++++++++++
 tb/tb_pipearch_storereg.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipearch_storereg.sv
// Register-store engine: read-modify-write of one 32-bit word inside a 512-bit
// region line, launched and acknowledged through the op_start/op_done handshake.
module pipearch_storereg (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    output logic              op_done,
    input  logic [2:0][31:0]  regs,
    input  logic [4:0][31:0]  inregs,
    output logic              REGION_read_re,
    output logic [15:0]       REGION_read_raddr,
    input  logic              REGION_read_rvalid,
    input  logic [511:0]      REGION_read_rdata,
    output logic              REGION_write_we,
    output logic [15:0]       REGION_write_waddr,
    output logic [511:0]      REGION_write_wdata,
    output logic [1:0]        state_dbg_o
);

    // Handshake: op_start is a one-cycle pulse honoured only in IDLE; op_done is a
    // one-cycle pulse; re/we are one-cycle strobes qualifying raddr/waddr/wdata.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        RECEIVE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    index_q, index_d;
    logic [2:0]     sel_q, sel_d;
    logic [15:0]    base_q, base_d;
    logic [31:0]    value_q, value_d;
    logic           re_q, re_d;
    logic [15:0]    raddr_q, raddr_d;
    logic           we_q, we_d;
    logic [15:0]    waddr_q, waddr_d;
    logic [511:0]   wdata_q, wdata_d;
    logic           done_q, done_d;
    logic           sel_ok;

    wire unused_bits = ^{regs[0][31:16], regs[1][31:3], regs[2][31:16], inregs[2:0]};

    assign sel_ok = (sel_q == 3'd3) || (sel_q == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    // Operands and line data need no reset; they are only meaningful under a strobe.
    always_ff @(posedge clk) begin
        index_q <= index_d;
        sel_q   <= sel_d;
        base_q  <= base_d;
        value_q <= value_d;
        raddr_q <= raddr_d;
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_start) state_d = READ;
            READ:    state_d = sel_ok ? RECEIVE : IDLE;
            RECEIVE: if (REGION_read_rvalid) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        index_d = index_q;
        sel_d   = sel_q;
        base_d  = base_q;
        value_d = value_q;
        re_d    = 1'b0;
        raddr_d = raddr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_start) begin
                    index_d = regs[0][15:0];
                    sel_d   = regs[1][2:0];
                    base_d  = regs[2][15:0];
                    if (regs[1][2:0] == 3'd3)      value_d = inregs[3];
                    else if (regs[1][2:0] == 3'd4) value_d = inregs[4];
                    else                           value_d = '0;
                end
            end
            READ: begin
                if (sel_ok) begin
                    re_d    = 1'b1;
                    raddr_d = base_q + {4'd0, index_q[15:4]};
                end else begin
                    done_d  = 1'b1;
                end
            end
            RECEIVE: begin
                if (REGION_read_rvalid) begin
                    wdata_d = REGION_read_rdata;
                    wdata_d[{index_q[3:0], 5'd0} +: 32] = value_q;
                    waddr_d = raddr_q;
                    we_d    = 1'b1;
                end
            end
            WRITE:   done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    assign op_done            = done_q;
    assign REGION_read_re     = re_q;
    assign REGION_read_raddr  = raddr_q;
    assign REGION_write_we    = we_q;
    assign REGION_write_waddr = waddr_q;
    assign REGION_write_wdata = wdata_q;
    assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_pipearch_storereg.sv
// Bench for pipearch_storereg: behavioural BRAM with programmable read latency,
// word-level store model and per-scenario checks on addresses, data and timing.
module tb_pipearch_storereg;

    logic             clk = 1'b0;
    logic             reset;
    logic             op_start;
    logic             op_done;
    logic [2:0][31:0] regs;
    logic [4:0][31:0] inregs;
    logic             re;
    logic [15:0]      raddr;
    logic             rvalid = 1'b0;
    logic [511:0]     rdata = '0;
    logic             we;
    logic [15:0]      waddr;
    logic [511:0]     wdata;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    pipearch_storereg dut (
        .clk                (clk),
        .reset              (reset),
        .op_start           (op_start),
        .op_done            (op_done),
        .regs               (regs),
        .inregs             (inregs),
        .REGION_read_re     (re),
        .REGION_read_raddr  (raddr),
        .REGION_read_rvalid (rvalid),
        .REGION_read_rdata  (rdata),
        .REGION_write_we    (we),
        .REGION_write_waddr (waddr),
        .REGION_write_wdata (wdata),
        .state_dbg_o        (state_dbg)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bram_lat = 2;
    int rd_pend = 0;
    int rv_cyc = -1;
    logic [15:0]  rd_addr;
    logic [511:0] mem [logic [15:0]];

    int           re_cyc_q[$];
    logic [15:0]  re_addr_q[$];
    int           we_cyc_q[$];
    logic [15:0]  we_addr_q[$];
    logic [511:0] we_data_q[$];
    int           done_cyc_q[$];
    logic [511:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    // Reference: split the line into 16 words, replace one, reassemble.
    function automatic logic [511:0] model_store(logic [511:0] old, int pos, logic [31:0] val);
        logic [31:0]  words [16];
        logic [511:0] res;
        for (int i = 0; i < 16; i++) words[i] = old[i*32 +: 32];
        words[pos] = val;
        res = '0;
        for (int i = 15; i >= 0; i--) res = {res[479:0], words[i]};
        return res;
    endfunction

    function automatic logic [15:0] line_addr(logic [15:0] idx, logic [15:0] base);
        int a;
        a = (int'(base) + int'(idx) / 16) % 65536;
        return a[15:0];
    endfunction

    // BRAM model and output monitor, both sampled mid-cycle.
    always @(negedge clk) begin
        rvalid = 1'b0;
        if (rd_pend > 0) begin
            rd_pend--;
            if (rd_pend == 0) begin
                if (!mem.exists(rd_addr)) mem[rd_addr] = rand_line();
                rdata = mem[rd_addr];
                rvalid = 1'b1;
                rv_cyc = cyc;
            end
        end
        if (re) begin
            re_cyc_q.push_back(cyc);
            re_addr_q.push_back(raddr);
            rd_addr = raddr;
            if (bram_lat <= 1) begin
                if (!mem.exists(rd_addr)) mem[rd_addr] = rand_line();
                rdata = mem[rd_addr];
                rvalid = 1'b1;
                rv_cyc = cyc;
            end else begin
                rd_pend = bram_lat - 1;
            end
        end
        if (we) begin
            we_cyc_q.push_back(cyc);
            we_addr_q.push_back(waddr);
            we_data_q.push_back(wdata);
            mem[waddr] = wdata;
        end
        if (op_done) done_cyc_q.push_back(cyc);
    end

    task automatic clear_logs();
        re_cyc_q.delete(); re_addr_q.delete();
        we_cyc_q.delete(); we_addr_q.delete(); we_data_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic launch(input logic [15:0] idx, input logic [2:0] sel,
                          input logic [15:0] base, output int start);
        @(posedge clk); #1;
        regs[0] = {16'h0, idx};
        regs[1] = {29'h0, sel};
        regs[2] = {16'h0, base};
        op_start = 1'b1;
        start = cyc;
        @(posedge clk); #1;
        op_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cyc_q.size() == 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_start = 1'b0; regs = '0; inregs = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (re !== 1'b0) begin bad++; $display("FAIL reset_re got=%b exp=0", re); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
        total++; if (op_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", op_done); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        reset = 1'b0;
    endtask

    task automatic test_store(input string name, input logic [15:0] idx, input logic [2:0] sel,
                              input logic [15:0] base, input logic [31:0] val, input int lat);
        logic [15:0]  a;
        logic [511:0] e;
        int           start;
        a = line_addr(idx, base);
        if (!mem.exists(a)) mem[a] = rand_line();
        exp_q.push_back(model_store(mem[a], int'(idx) % 16, val));
        bram_lat = lat;
        inregs[3] = $urandom; inregs[4] = $urandom;
        inregs[sel] = val;
        clear_logs();
        launch(idx, sel, base, start);
        wait_done(lat + 12);
        repeat (3) @(posedge clk);
        e = exp_q.pop_front();
        total++; if (re_cyc_q.size() != 1) begin bad++; $display("FAIL %s re_count got=%0d exp=1", name, re_cyc_q.size()); end
        total++; if (we_cyc_q.size() != 1) begin bad++; $display("FAIL %s we_count got=%0d exp=1", name, we_cyc_q.size()); end
        total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL %s done_count got=%0d exp=1", name, done_cyc_q.size()); end
        if (re_cyc_q.size() > 0) begin
            total++; if (re_addr_q[0] !== a) begin bad++; $display("FAIL %s raddr got=%h exp=%h", name, re_addr_q[0], a); end
            total++; if (re_cyc_q[0] != start + 2) begin bad++; $display("FAIL %s re_cycle got=%0d exp=%0d", name, re_cyc_q[0], start + 2); end
        end
        if (we_cyc_q.size() > 0) begin
            total++; if (we_addr_q[0] !== a) begin bad++; $display("FAIL %s waddr got=%h exp=%h", name, we_addr_q[0], a); end
            total++; if (we_data_q[0] !== e) begin bad++; $display("FAIL %s wdata got=%h exp=%h", name, we_data_q[0], e); end
            total++; if (we_cyc_q[0] != start + lat + 2) begin bad++; $display("FAIL %s we_cycle got=%0d exp=%0d", name, we_cyc_q[0], start + lat + 2); end
        end
        if (done_cyc_q.size() > 0) begin
            total++; if (done_cyc_q[0] != start + lat + 3) begin bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc_q[0], start + lat + 3); end
        end
    endtask

    task automatic test_basic();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = i;
        mem[16'h0010] = l;
        test_store("basic", 16'h0000, 3'd3, 16'h0010, 32'hDEADBEEF, 2);
        total++;
        if (mem[16'h0010][511:32] !== l[511:32] || mem[16'h0010][31:0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL basic_line got=%h exp_word0=deadbeef", mem[16'h0010]);
        end
    endtask

    task automatic test_top_word();
        test_store("top_word", 16'h002F, 3'd4, 16'h0100, 32'h12345678, 3);
        total++;
        if (mem[16'h0102][511:480] !== 32'h12345678) begin
            bad++; $display("FAIL top_word_bits got=%h exp=12345678", mem[16'h0102][511:480]);
        end
    endtask

    task automatic test_wrap();
        test_store("wrap", 16'h0010, 3'd3, 16'hFFFF, $urandom, 2);
    endtask

    task automatic test_invalid();
        logic [2:0] sels [6] = '{3'd2, 3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
        int start;
        for (int k = 0; k < 6; k++) begin
            clear_logs();
            launch(16'($urandom), sels[k], 16'($urandom), start);
            repeat (8) @(posedge clk);
            total++; if (re_cyc_q.size() != 0) begin bad++; $display("FAIL invalid_re sel=%0d got=%0d exp=0", sels[k], re_cyc_q.size()); end
            total++; if (we_cyc_q.size() != 0) begin bad++; $display("FAIL invalid_we sel=%0d got=%0d exp=0", sels[k], we_cyc_q.size()); end
            total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL invalid_done_count sel=%0d got=%0d exp=1", sels[k], done_cyc_q.size()); end
            if (done_cyc_q.size() > 0) begin
                total++; if (done_cyc_q[0] != start + 2) begin bad++; $display("FAIL invalid_done_cycle sel=%0d got=%0d exp=%0d", sels[k], done_cyc_q[0], start + 2); end
            end
        end
    endtask

    task automatic test_busy();
        logic [15:0]  a;
        logic [511:0] e;
        int           start;
        a = line_addr(16'h0043, 16'h0400);
        if (!mem.exists(a)) mem[a] = rand_line();
        inregs[3] = $urandom;
        e = model_store(mem[a], 3, inregs[3]);
        bram_lat = 5;
        clear_logs();
        launch(16'h0043, 3'd3, 16'h0400, start);
        @(posedge clk); #1;
        @(posedge clk); #1;
        regs[0] = 32'h0000_0007; regs[1] = 32'd4; regs[2] = 32'h0000_0800;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        wait_done(20);
        repeat (10) @(posedge clk);
        total++; if (done_cyc_q.size() != 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", done_cyc_q.size()); end
        total++; if (re_cyc_q.size() != 1) begin bad++; $display("FAIL busy_re_count got=%0d exp=1", re_cyc_q.size()); end
        total++; if (we_cyc_q.size() != 1) begin bad++; $display("FAIL busy_we_count got=%0d exp=1", we_cyc_q.size()); end
        if (we_cyc_q.size() > 0) begin
            total++; if (we_data_q[0] !== e || we_addr_q[0] !== a) begin bad++; $display("FAIL busy_write got=%h@%h exp=%h@%h", we_data_q[0], we_addr_q[0], e, a); end
        end
    endtask

    task automatic test_reset_mid();
        int start;
        bram_lat = 5;
        inregs[4] = $urandom;
        clear_logs();
        launch(16'h0015, 3'd4, 16'h0500, start);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (state_dbg !== 2'd0 || re !== 1'b0 || we !== 1'b0 || op_done !== 1'b0) begin
            bad++; $display("FAIL rst_mid_idle got=state%0d/re%b/we%b/done%b exp=0/0/0/0", state_dbg, re, we, op_done);
        end
        repeat (12) @(posedge clk);
        total++; if (we_cyc_q.size() != 0) begin bad++; $display("FAIL rst_mid_we got=%0d exp=0", we_cyc_q.size()); end
        total++; if (done_cyc_q.size() != 0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", done_cyc_q.size()); end
        test_store("after_reset", 16'h0015, 3'd4, 16'h0500, $urandom, 2);
    endtask

    task automatic test_delay();
        logic [15:0]  a;
        logic [511:0] e;
        logic [31:0]  v0;
        int           start;
        a = line_addr(16'h0369, 16'h0600);
        if (!mem.exists(a)) mem[a] = rand_line();
        v0 = $urandom;
        inregs[3] = v0;
        e = model_store(mem[a], 9, v0);
        bram_lat = 5;
        clear_logs();
        launch(16'h0369, 3'd3, 16'h0600, start);
        inregs[3] = ~v0;
        wait_done(20);
        repeat (3) @(posedge clk);
        total++; if (we_cyc_q.size() != 1) begin bad++; $display("FAIL delay_we_count got=%0d exp=1", we_cyc_q.size()); end
        if (we_cyc_q.size() > 0) begin
            total++; if (we_data_q[0] !== e) begin bad++; $display("FAIL delay_wdata got=%h exp=%h", we_data_q[0], e); end
            total++; if (we_cyc_q[0] != rv_cyc + 1) begin bad++; $display("FAIL delay_we_cycle got=%0d exp=%0d", we_cyc_q[0], rv_cyc + 1); end
        end
        total++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != start + 8) begin
            bad++; $display("FAIL delay_done got_count=%0d exp_cycle=%0d", done_cyc_q.size(), start + 8);
        end
    endtask

    task automatic test_reset_start();
        clear_logs();
        bram_lat = 2;
        @(posedge clk); #1;
        reset = 1'b1; op_start = 1'b1;
        regs[0] = 32'h0000_0001; regs[1] = 32'd3; regs[2] = 32'h0000_0700;
        @(posedge clk); #1;
        reset = 1'b0; op_start = 1'b0;
        repeat (8) @(posedge clk);
        total++; if (re_cyc_q.size() != 0) begin bad++; $display("FAIL rst_start_re got=%0d exp=0", re_cyc_q.size()); end
        total++; if (done_cyc_q.size() != 0) begin bad++; $display("FAIL rst_start_done got=%0d exp=0", done_cyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [511:0] e1;
        logic [15:0]  a1;
        int           s0, s1;
        a1 = line_addr(16'h0024, 16'h3000);
        if (!mem.exists(a1)) mem[a1] = rand_line();
        inregs[3] = $urandom; inregs[4] = $urandom;
        e1 = model_store(mem[a1], 4, inregs[4]);
        bram_lat = 2;
        clear_logs();
        launch(16'h0011, 3'd3, 16'h2000, s0);
        repeat (3) @(posedge clk);
        launch(16'h0024, 3'd4, 16'h3000, s1);
        wait_done(20);
        repeat (10) @(posedge clk);
        total++; if (s1 != s0 + 5) begin bad++; $display("FAIL b2b_launch_cycle got=%0d exp=%0d", s1, s0 + 5); end
        total++; if (done_cyc_q.size() != 2 || we_cyc_q.size() != 2) begin
            bad++; $display("FAIL b2b_counts got=done%0d/we%0d exp=2/2", done_cyc_q.size(), we_cyc_q.size());
        end else begin
            total++; if (done_cyc_q[0] != s1) begin bad++; $display("FAIL b2b_overlap got=%0d exp=%0d", done_cyc_q[0], s1); end
            total++; if (done_cyc_q[1] != s1 + 5) begin bad++; $display("FAIL b2b_done2 got=%0d exp=%0d", done_cyc_q[1], s1 + 5); end
            total++; if (we_data_q[1] !== e1 || we_addr_q[1] !== a1) begin bad++; $display("FAIL b2b_write2 got=%h@%h exp=%h@%h", we_data_q[1], we_addr_q[1], e1, a1); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            test_store("random", 16'($urandom), ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4,
                       16'($urandom), $urandom, int'($urandom_range(1, 5)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_top_word();
        test_wrap();
        test_invalid();
        test_busy();
        test_reset_mid();
        test_delay();
        test_reset_start();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
